// File: rtl/encoder_step_ctl_pkg.sv
// Shared FSM state encoding and default parameter values for the encoder step controller.
package encoder_step_ctl_pkg;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StHold = 2'd2;

    localparam int unsigned DefNch       = 2;
    localparam int unsigned DefCntW      = 16;
    localparam int unsigned DefPwmW      = 16;
    localparam int unsigned DefPwmPeriod = 10000;
    localparam int unsigned DefSpeed     = 8000;
    localparam int unsigned DefRampStep  = 1000;
    localparam int unsigned DefStallCyc  = 4_000_000;

    // Width of the per-channel stall timer.
    localparam int unsigned StallW = 24;

endpackage

// File: rtl/encoder_step_ctl_step_chan.sv
// One motor channel: encoder synchroniser, tick counter, move FSM, duty ramp and stall timer.
module step_chan
    import encoder_step_ctl_pkg::*;
#(
    parameter int unsigned CNT_W     = DefCntW,
    parameter int unsigned PWM_W     = DefPwmW,
    parameter int unsigned SPEED     = DefSpeed,
    parameter int unsigned RAMP_STEP = DefRampStep,
    parameter int unsigned STALL_CYC = DefStallCyc
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] target,
    input  logic             dir_req,
    input  logic             encdr,
    input  logic [PWM_W-1:0] pwm_cnt,
    input  logic             pwm_wrap,
    output logic             pwm,
    output logic             en,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    logic              sync1_q, sync2_q, edge_q;
    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  tgt_q, tgt_d;
    logic              dir_q, dir_d;
    logic [PWM_W-1:0]  duty_q, duty_d;
    logic [StallW-1:0] timer_q, timer_d;
    logic              stall_q, stall_d;
    logic              enc_rise;
    logic [PWM_W:0]    duty_sum;
    logic [StallW:0]   timer_inc;

    assign enc_rise  = sync2_q & ~edge_q;
    // One extra bit so the ramp cannot wrap before saturation.
    assign duty_sum  = {1'b0, duty_q} + (PWM_W+1)'(RAMP_STEP);
    assign timer_inc = {1'b0, timer_q} + (StallW+1)'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= encdr;
            sync2_q <= sync1_q;
            edge_q  <= sync2_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        dir_d   = dir_q;
        duty_d  = duty_q;
        timer_d = timer_q;
        stall_d = stall_q;
        case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    tgt_d   = target;
                    dir_d   = dir_req;
                    cnt_d   = '0;
                    duty_d  = '0;
                    timer_d = '0;
                    stall_d = 1'b0;
                    state_d = (target == '0) ? StHold : StRun;
                end
            end
            StRun: begin
                if (enc_rise) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (pwm_wrap) begin
                    duty_d = (duty_sum > (PWM_W+1)'(SPEED)) ? PWM_W'(SPEED)
                                                            : duty_sum[PWM_W-1:0];
                end
                // Reaching the target outranks a simultaneous stall timeout.
                if (cnt_d == tgt_q) begin
                    state_d = StHold;
                end else if (enc_rise) begin
                    timer_d = '0;
                end else if (timer_inc >= (StallW+1)'(STALL_CYC)) begin
                    stall_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    timer_d = timer_inc[StallW-1:0];
                end
            end
            StHold: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (abort) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            tgt_q   <= '0;
            dir_q   <= 1'b0;
            duty_q  <= '0;
            timer_q <= '0;
            stall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            dir_q   <= dir_d;
            duty_q  <= duty_d;
            timer_q <= timer_d;
            stall_q <= stall_d;
        end
    end

    assign pwm   = (state_q == StRun) && (pwm_cnt < duty_q);
    assign en    = (state_q == StRun);
    assign busy  = (state_q != StIdle);
    assign done  = (state_q == StHold);
    assign dir   = dir_q;
    assign stall = stall_q;

endmodule

// File: rtl/encoder_step_ctl.sv
// Multi-channel encoder-counted step controller with a shared free-running PWM counter.
module encoder_step_ctl
    import encoder_step_ctl_pkg::*;
#(
    parameter int unsigned NCH        = DefNch,
    parameter int unsigned CNT_W      = DefCntW,
    parameter int unsigned PWM_W      = DefPwmW,
    parameter int unsigned PWM_PERIOD = DefPwmPeriod,
    parameter int unsigned SPEED      = DefSpeed,
    parameter int unsigned RAMP_STEP  = DefRampStep,
    parameter int unsigned STALL_CYC  = DefStallCyc
) (
    input  logic                 WF_CLK,
    input  logic                 WF_RSTN,
    input  logic [NCH-1:0]       start,
    input  logic                 abort,
    input  logic [NCH*CNT_W-1:0] target,
    input  logic [NCH-1:0]       dir_req,
    input  logic [NCH-1:0]       encdr,
    output logic [NCH-1:0]       pwm,
    output logic [NCH-1:0]       en,
    output logic [NCH-1:0]       dir,
    output logic [NCH-1:0]       busy,
    output logic [NCH-1:0]       done,
    output logic [NCH-1:0]       stall
);

    logic [PWM_W-1:0] pwm_cnt_q;
    logic             pwm_wrap;

    assign pwm_wrap = (pwm_cnt_q == PWM_W'(PWM_PERIOD - 1));

    always_ff @(posedge WF_CLK or negedge WF_RSTN) begin
        if (!WF_RSTN) begin
            pwm_cnt_q <= '0;
        end else if (pwm_wrap) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + PWM_W'(1);
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        step_chan #(
            .CNT_W     (CNT_W),
            .PWM_W     (PWM_W),
            .SPEED     (SPEED),
            .RAMP_STEP (RAMP_STEP),
            .STALL_CYC (STALL_CYC)
        ) u_chan (
            .clk      (WF_CLK),
            .rst_n    (WF_RSTN),
            .start    (start[i]),
            .abort    (abort),
            .target   (target[i*CNT_W +: CNT_W]),
            .dir_req  (dir_req[i]),
            .encdr    (encdr[i]),
            .pwm_cnt  (pwm_cnt_q),
            .pwm_wrap (pwm_wrap),
            .pwm      (pwm[i]),
            .en       (en[i]),
            .dir      (dir[i]),
            .busy     (busy[i]),
            .done     (done[i]),
            .stall    (stall[i])
        );
    end

endmodule

// File: tb/tb_encoder_step_ctl.sv
// Randomized scenario bench for encoder_step_ctl with a behavioural move/ramp/stall model.
module tb_encoder_step_ctl;

    localparam int PERIOD  = 100;
    localparam int SPEED   = 60;
    localparam int RAMP    = 20;
    localparam int STALL_A = 1000;
    localparam int STALL_B = 50;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  a_start, a_dir_req, a_encdr;
    logic        a_abort;
    logic [31:0] a_target;
    logic [1:0]  a_pwm, a_en, a_dir, a_busy, a_done, a_stall;
    logic [1:0]  b_start, b_dir_req, b_encdr;
    logic        b_abort;
    logic [31:0] b_target;
    logic [1:0]  b_pwm, b_en, b_dir, b_busy, b_done, b_stall;

    int n_pass = 0;
    int n_chk  = 0;
    int done_cnt [2] = '{0, 0};
    int b_done_cnt = 0;
    int dir_err = 0;
    int run_len = 0;
    int bursts[$];
    logic [1:0] exp_dir = 2'b00;

    always #5 clk = ~clk;

    encoder_step_ctl #(
        .NCH(2), .CNT_W(16), .PWM_W(16), .PWM_PERIOD(PERIOD), .SPEED(SPEED),
        .RAMP_STEP(RAMP), .STALL_CYC(STALL_A)
    ) dut (
        .WF_CLK(clk), .WF_RSTN(rst_n), .start(a_start), .abort(a_abort),
        .target(a_target), .dir_req(a_dir_req), .encdr(a_encdr), .pwm(a_pwm),
        .en(a_en), .dir(a_dir), .busy(a_busy), .done(a_done), .stall(a_stall)
    );

    encoder_step_ctl #(
        .NCH(2), .CNT_W(16), .PWM_W(16), .PWM_PERIOD(PERIOD), .SPEED(SPEED),
        .RAMP_STEP(RAMP), .STALL_CYC(STALL_B)
    ) dut_stall (
        .WF_CLK(clk), .WF_RSTN(rst_n), .start(b_start), .abort(b_abort),
        .target(b_target), .dir_req(b_dir_req), .encdr(b_encdr), .pwm(b_pwm),
        .en(b_en), .dir(b_dir), .busy(b_busy), .done(b_done), .stall(b_stall)
    );

    // Event monitor: done pulses, dir stability while busy, pwm[0] burst lengths.
    always @(posedge clk) begin
        #1;
        for (int c = 0; c < 2; c++) begin
            if (a_done[c] === 1'b1) done_cnt[c]++;
            if (a_busy[c] === 1'b1 && a_dir[c] !== exp_dir[c]) dir_err++;
        end
        if (b_done[0] === 1'b1) b_done_cnt++;
        if (a_pwm[0] === 1'b1) begin
            run_len++;
        end else if (run_len > 0) begin
            bursts.push_back(run_len);
            run_len = 0;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [1:0] mask, input int gap);
        a_encdr = a_encdr | mask;
        cyc(2);
        a_encdr = a_encdr & ~mask;
        cyc(gap);
    endtask

    task automatic start_a(input int ch, input int tgt, input logic d);
        a_target[ch*16 +: 16] = 16'(tgt);
        a_dir_req[ch] = d;
        exp_dir[ch] = d;
        a_start[ch] = 1'b1;
        cyc(1);
        a_start[ch] = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        a_start = '0; a_dir_req = '0; a_encdr = '0; a_abort = 1'b0; a_target = '0;
        b_start = '0; b_dir_req = '0; b_encdr = '0; b_abort = 1'b0; b_target = '0;
        cyc(3);
        n_chk++;
        if ({a_pwm, a_en, a_dir, a_busy, a_done, a_stall} !== 12'h0)
            $display("FAIL reset_outputs_a: got %h expected 0",
                     {a_pwm, a_en, a_dir, a_busy, a_done, a_stall});
        else n_pass++;
        n_chk++;
        if ({b_pwm, b_en, b_dir, b_busy, b_done, b_stall} !== 12'h0)
            $display("FAIL reset_outputs_b: got %h expected 0",
                     {b_pwm, b_en, b_dir, b_busy, b_done, b_stall});
        else n_pass++;
        rst_n = 1'b1;
        cyc(3);
        n_chk++;
        if (a_busy !== 2'b00) $display("FAIL idle_after_reset: busy %b expected 00", a_busy);
        else n_pass++;
    endtask

    task automatic test_ramp;
        int b0, d0, lat, exp_len;
        logic d;
        b0 = bursts.size();
        d0 = done_cnt[0];
        d = 1'($urandom_range(0, 1));
        start_a(0, 5, d);
        n_chk++;
        if (a_en[0] !== 1'b1 || a_busy[0] !== 1'b1)
            $display("FAIL en_after_start: en %b busy %b expected 1 1", a_en[0], a_busy[0]);
        else n_pass++;
        n_chk++;
        if (a_dir[0] !== d) $display("FAIL dir_latched: got %b expected %b", a_dir[0], d);
        else n_pass++;
        pulse(2'b01, 130 + $urandom_range(0, 30));
        pulse(2'b01, 130 + $urandom_range(0, 30));
        // Start while busy, with a different target and direction: must be ignored.
        a_target[15:0] = 16'd1;
        a_dir_req[0] = ~d;
        a_start[0] = 1'b1;
        cyc(1);
        a_start[0] = 1'b0;
        pulse(2'b01, 130 + $urandom_range(0, 30));
        pulse(2'b01, 130 + $urandom_range(0, 30));
        n_chk++;
        if (done_cnt[0] - d0 !== 0) $display("FAIL early_done: got %0d expected 0", done_cnt[0] - d0);
        else n_pass++;
        lat = 0;
        a_encdr[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cyc(1);
            if (k == 2) a_encdr[0] = 1'b0;
            if (a_done[0] === 1'b1 && lat == 0) lat = k;
        end
        n_chk++;
        if (lat < 3 || lat > 4) $display("FAIL done_latency: got %0d expected 3..4", lat);
        else n_pass++;
        n_chk++;
        if (done_cnt[0] - d0 !== 1) $display("FAIL done_once: got %0d expected 1", done_cnt[0] - d0);
        else n_pass++;
        n_chk++;
        if ({a_en[0], a_pwm[0], a_busy[0]} !== 3'b000)
            $display("FAIL stopped_after_done: en/pwm/busy %b expected 000",
                     {a_en[0], a_pwm[0], a_busy[0]});
        else n_pass++;
        n_chk++;
        if (bursts.size() - b0 < 4) begin
            $display("FAIL burst_count: got %0d expected >=4", bursts.size() - b0);
        end else begin
            n_pass++;
            for (int k = 0; k < 4; k++) begin
                exp_len = ((k + 1) * RAMP > SPEED) ? SPEED : (k + 1) * RAMP;
                n_chk++;
                if (bursts[b0 + k] !== exp_len)
                    $display("FAIL duty_ramp_%0d: got %0d expected %0d", k, bursts[b0 + k], exp_len);
                else n_pass++;
            end
        end
        n_chk++;
        if (dir_err !== 0) $display("FAIL dir_stable: got %0d changes expected 0", dir_err);
        else n_pass++;
    endtask

    task automatic test_two_ch;
        int d0, d1;
        d0 = done_cnt[0];
        d1 = done_cnt[1];
        a_target = {16'd7, 16'd3};
        a_dir_req = 2'($urandom_range(0, 3));
        exp_dir = a_dir_req;
        a_start = 2'b11;
        cyc(1);
        a_start = 2'b00;
        for (int p = 1; p <= 7; p++) begin
            pulse(2'b11, 8 + $urandom_range(0, 12));
            n_chk++;
            if (done_cnt[0] - d0 !== ((p >= 3) ? 1 : 0))
                $display("FAIL ch0_done_p%0d: got %0d expected %0d", p, done_cnt[0] - d0, (p >= 3) ? 1 : 0);
            else n_pass++;
            n_chk++;
            if (done_cnt[1] - d1 !== ((p >= 7) ? 1 : 0))
                $display("FAIL ch1_done_p%0d: got %0d expected %0d", p, done_cnt[1] - d1, (p >= 7) ? 1 : 0);
            else n_pass++;
            n_chk++;
            if (a_busy[1] !== (p < 7))
                $display("FAIL ch1_busy_p%0d: got %b expected %b", p, a_busy[1], (p < 7));
            else n_pass++;
        end
    endtask

    task automatic test_random_moves;
        int tgt, d0;
        for (int m = 0; m < 3; m++) begin
            tgt = $urandom_range(1, 6);
            d0 = done_cnt[0];
            start_a(0, tgt, 1'($urandom_range(0, 1)));
            for (int p = 1; p <= tgt; p++) begin
                pulse(2'b01, 8 + $urandom_range(0, 20));
                n_chk++;
                if (done_cnt[0] - d0 !== ((p == tgt) ? 1 : 0) || a_busy[0] !== (p < tgt))
                    $display("FAIL rand_move_t%0d_p%0d: done %0d busy %b expected %0d %b", tgt, p,
                             done_cnt[0] - d0, a_busy[0], (p == tgt) ? 1 : 0, (p < tgt));
                else n_pass++;
            end
        end
    endtask

    task automatic test_zero_target;
        int d0, busy_len;
        logic en_seen;
        d0 = done_cnt[0];
        busy_len = 0;
        en_seen = 1'b0;
        a_target[15:0] = 16'd0;
        a_start[0] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc(1);
            a_start[0] = 1'b0;
            if (a_en[0] === 1'b1) en_seen = 1'b1;
            if (a_busy[0] === 1'b1) busy_len++;
        end
        n_chk++;
        if (done_cnt[0] - d0 !== 1) $display("FAIL zero_done: got %0d expected 1", done_cnt[0] - d0);
        else n_pass++;
        n_chk++;
        if (en_seen !== 1'b0) $display("FAIL zero_en: got %b expected 0", en_seen);
        else n_pass++;
        n_chk++;
        if (busy_len < 1 || busy_len > 2) $display("FAIL zero_busy: got %0d expected 1..2", busy_len);
        else n_pass++;
    endtask

    task automatic test_abort;
        int d0;
        d0 = done_cnt[0];
        start_a(0, 10, 1'($urandom_range(0, 1)));
        pulse(2'b01, 10);
        pulse(2'b01, 10);
        a_abort = 1'b1;
        cyc(1);
        a_abort = 1'b0;
        n_chk++;
        if ({a_en[0], a_pwm[0], a_busy[0]} !== 3'b000)
            $display("FAIL abort_stop: en/pwm/busy %b expected 000", {a_en[0], a_pwm[0], a_busy[0]});
        else n_pass++;
        cyc(4);
        n_chk++;
        if (done_cnt[0] - d0 !== 0) $display("FAIL abort_no_done: got %0d expected 0", done_cnt[0] - d0);
        else n_pass++;
        a_target[15:0] = 16'd4;
        a_abort = 1'b1;
        a_start[0] = 1'b1;
        cyc(1);
        a_abort = 1'b0;
        a_start[0] = 1'b0;
        n_chk++;
        if (a_busy[0] !== 1'b0) $display("FAIL abort_wins: busy %b expected 0", a_busy[0]);
        else n_pass++;
        start_a(0, 3, 1'($urandom_range(0, 1)));
        for (int p = 1; p <= 3; p++) begin
            pulse(2'b01, 10);
            n_chk++;
            if (done_cnt[0] - d0 !== ((p == 3) ? 1 : 0))
                $display("FAIL restart_count_p%0d: got %0d expected %0d", p, done_cnt[0] - d0,
                         (p == 3) ? 1 : 0);
            else n_pass++;
        end
    endtask

    task automatic test_stall;
        int bd0, lat;
        logic en_at;
        bd0 = b_done_cnt;
        lat = 0;
        en_at = 1'b1;
        b_target[15:0] = 16'd5;
        b_start[0] = 1'b1;
        for (int k = 1; k <= 80; k++) begin
            cyc(1);
            b_start[0] = 1'b0;
            if (b_stall[0] === 1'b1 && lat == 0) begin
                lat = k;
                en_at = b_en[0];
            end
        end
        n_chk++;
        if (lat < STALL_B || lat > STALL_B + 2)
            $display("FAIL stall_time: got %0d expected %0d..%0d", lat, STALL_B, STALL_B + 2);
        else n_pass++;
        n_chk++;
        if (en_at !== 1'b0) $display("FAIL stall_en: got %b expected 0", en_at);
        else n_pass++;
        n_chk++;
        if (b_stall[0] !== 1'b1 || b_busy[0] !== 1'b0)
            $display("FAIL stall_sticky: stall %b busy %b expected 1 0", b_stall[0], b_busy[0]);
        else n_pass++;
        n_chk++;
        if (b_done_cnt - bd0 !== 0) $display("FAIL stall_no_done: got %0d expected 0", b_done_cnt - bd0);
        else n_pass++;
        b_target[15:0] = 16'd3;
        b_start[0] = 1'b1;
        cyc(1);
        b_start[0] = 1'b0;
        n_chk++;
        if (b_stall[0] !== 1'b0 || b_busy[0] !== 1'b1)
            $display("FAIL stall_clear: stall %b busy %b expected 0 1", b_stall[0], b_busy[0]);
        else n_pass++;
        b_abort = 1'b1;
        cyc(1);
        b_abort = 1'b0;
    endtask

    task automatic test_reset_mid;
        int d0, d1;
        a_target = {16'd8, 16'd8};
        a_dir_req = 2'b11;
        exp_dir = 2'b11;
        a_start = 2'b11;
        cyc(1);
        a_start = 2'b00;
        pulse(2'b11, 10);
        pulse(2'b11, 10);
        n_chk++;
        if (a_en !== 2'b11) $display("FAIL running_before_reset: en %b expected 11", a_en);
        else n_pass++;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({a_pwm, a_en, a_dir, a_busy, a_done, a_stall} !== 12'h0)
            $display("FAIL async_reset: got %h expected 0", {a_pwm, a_en, a_dir, a_busy, a_done, a_stall});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        d0 = done_cnt[0];
        d1 = done_cnt[1];
        for (int p = 0; p < 8; p++) pulse(2'b11, 8);
        n_chk++;
        if (a_busy !== 2'b00 || a_en !== 2'b00 || done_cnt[0] - d0 !== 0 || done_cnt[1] - d1 !== 0)
            $display("FAIL need_new_start: busy %b en %b done %0d/%0d expected 00 00 0/0",
                     a_busy, a_en, done_cnt[0] - d0, done_cnt[1] - d1);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_two_ch();
        test_random_moves();
        test_zero_target();
        test_abort();
        test_stall();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
